// File: rtl/emern_spi_pkg.sv
// Shared types and defaults for the emern SPI command master.
// The WAIT_INT state is only reachable when EMERN_SPI_WAIT_INT_EN is defined.
package emern_spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_INT = 3'd1,
    CS_SETUP = 3'd2,
    SHIFT    = 3'd3,
    NEXT     = 3'd4,
    CS_HOLD  = 3'd5,
    GAP      = 3'd6
  } spi_state_e;

  localparam int DEFAULT_CLK_DIV = 4;
  localparam int DEFAULT_CS_GAP  = 4;
  localparam int BITS_PER_BYTE   = 8;

  // States in which chip select is held low.
  function automatic logic cs_active(input spi_state_e s);
    return (s == CS_SETUP) || (s == SHIFT) || (s == NEXT) || (s == CS_HOLD);
  endfunction

endpackage

// File: rtl/emern_spi_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV enabled cycles, with a
// synchronous clear that restarts the count.
module emern_spi_tick_gen #(
  parameter int CLK_DIV = emern_spi_pkg::DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/emern_spi_cmd_master.sv
// SPI mode-0 initiator framing valid/ready byte packets as CS-low transactions.
// Define EMERN_SPI_WAIT_INT_EN to gate each transaction start on gpu_int.
module emern_spi_cmd_master
  import emern_spi_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int CS_GAP  = DEFAULT_CS_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic       gpu_int
);

  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  spi_state_e state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rx_shreg_q, rx_shreg_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          last_q, last_d;
  logic          rx_valid_q, rx_valid_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          phase_q, phase_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          tick;

`ifdef EMERN_SPI_WAIT_INT_EN
  logic [1:0] int_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_sync_q <= 2'b00;
    end else begin
      int_sync_q <= {int_sync_q[0], gpu_int};
    end
  end
`else
  logic unused_gpu_int;
  assign unused_gpu_int = gpu_int;
`endif

  emern_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en_i    ((state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == CS_HOLD)),
    .clear_i (state_d != state_q),
    .tick_o  (tick)
  );

  assign accept = tx_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    rx_shreg_d = rx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    sck_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = tx_data;
          last_d  = tx_last;
`ifdef EMERN_SPI_WAIT_INT_EN
          state_d = WAIT_INT;
`else
          state_d = CS_SETUP;
`endif
        end
      end
      WAIT_INT: begin
`ifdef EMERN_SPI_WAIT_INT_EN
        if (int_sync_q[1]) state_d = CS_SETUP;
`else
        state_d = IDLE;
`endif
      end
      CS_SETUP: begin
        if (tick) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
      end
      SHIFT: begin
        sck_d = sck_q;
        if (tick) begin
          if (!phase_q) begin
            // Rising edge: capture MISO in the same clock domain.
            phase_d    = 1'b1;
            sck_d      = 1'b1;
            rx_shreg_d = {rx_shreg_q[6:0], spi_miso};
          end else if (bit_cnt_q == LAST_BIT) begin
            sck_d      = 1'b0;
            rx_data_d  = rx_shreg_q;
            rx_valid_d = 1'b1;
            state_d    = last_q ? CS_HOLD : NEXT;
          end else begin
            sck_d     = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {shreg_q[6:0], 1'b0};
          end
        end
      end
      NEXT: begin
        if (accept) begin
          shreg_d   = tx_data;
          last_d    = tx_last;
          state_d   = SHIFT;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
      end
      CS_HOLD: begin
        if (tick) state_d = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pin-level outputs are registered from the next state so they change
    // together with the state register and never glitch.
    gap_cnt_d = ((state_q == GAP) && (state_d == GAP)) ? gap_cnt_q + GW'(1) : '0;
    cs_n_d    = !cs_active(state_d);
    mosi_d    = cs_active(state_d) ? shreg_d[7] : 1'b0;
    ready_d   = (state_d == IDLE) || (state_d == NEXT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      gap_cnt_q  <= '0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      rx_shreg_q <= rx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      gap_cnt_q  <= gap_cnt_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;

endmodule
